// File: rtl/shared_dreg_arbiter.sv
// Round-robin arbiter serialising two requesters' writes into one shared WIDTH-bit register.
// Latency: one edge from Req (in IDLE) to registered Q/Owner/Gnt/WrCount update.
// Backpressure: requests are ignored while Busy (GRANT + HOLD cycles); requesters hold Req until Gnt.
module shared_dreg_arbiter #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic [1:0]       Req,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    output logic [1:0]       Gnt,
    output logic [WIDTH-1:0] Q,
    output logic             Owner,
    output logic             Busy,
    output logic [7:0]       WrCount
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Hold counter load value; HOLD=0 never enters S_HOLD so the value is unused then.
    localparam logic [3:0] HOLD_LOAD = (HOLD > 0) ? 4'(HOLD - 1) : 4'd0;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             owner_nxt;
    logic [1:0]       gnt_nxt;
    logic             busy_nxt;
    logic [7:0]       wr_count_nxt;
    logic [3:0]       hold_cnt, hold_cnt_nxt;
    // Index of the last winner; reset to 1 so requester 0 wins the first tie.
    logic             last, last_nxt;
    logic             win;

    // Winner selection: a lone request wins outright, a tie goes to the requester that did not win last.
    always_comb begin
        win = 1'b0;
        if (Req == 2'b11) begin
            win = ~last;
        end else begin
            win = Req[1];
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt    = state;
        q_nxt        = Q;
        owner_nxt    = Owner;
        gnt_nxt      = 2'b00;
        busy_nxt     = Busy;
        wr_count_nxt = WrCount;
        hold_cnt_nxt = hold_cnt;
        last_nxt     = last;
        case (state)
            S_IDLE: begin
                if (Req != 2'b00) begin
                    q_nxt        = win ? D1 : D0;
                    owner_nxt    = win;
                    gnt_nxt      = win ? 2'b10 : 2'b01;
                    busy_nxt     = 1'b1;
                    wr_count_nxt = WrCount + 8'd1;
                    last_nxt     = win;
                    state_nxt    = S_GRANT;
                end
            end
            S_GRANT: begin
                if (HOLD == 0) begin
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    hold_cnt_nxt = HOLD_LOAD;
                    state_nxt    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt == 4'd0) begin
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt - 4'd1;
                end
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight GRANT/HOLD sequence.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            Q        <= '0;
            Owner    <= 1'b0;
            Gnt      <= 2'b00;
            Busy     <= 1'b0;
            WrCount  <= 8'd0;
            hold_cnt <= 4'd0;
            last     <= 1'b1;
        end else begin
            state    <= state_nxt;
            Q        <= q_nxt;
            Owner    <= owner_nxt;
            Gnt      <= gnt_nxt;
            Busy     <= busy_nxt;
            WrCount  <= wr_count_nxt;
            hold_cnt <= hold_cnt_nxt;
            last     <= last_nxt;
        end
    end

endmodule

// File: tb/tb_shared_dreg_arbiter.sv
module tb_shared_dreg_arbiter;

    logic       Clk;
    logic       Resetn;
    logic [1:0] Req;
    logic [7:0] D0;
    logic [7:0] D1;
    logic [1:0] Gnt;
    logic [7:0] Q;
    logic       Owner;
    logic       Busy;
    logic [7:0] WrCount;

    int errors;
    int checks;
    logic [7:0] exp_wr;

    shared_dreg_arbiter #(.WIDTH(8), .HOLD(2)) dut (
        .Clk     (Clk),
        .Resetn  (Resetn),
        .Req     (Req),
        .D0      (D0),
        .D1      (D1),
        .Gnt     (Gnt),
        .Q       (Q),
        .Owner   (Owner),
        .Busy    (Busy),
        .WrCount (WrCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One rising edge, then settle on the falling edge where outputs are sampled and inputs driven.
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        Req = 2'b11;
        D0 = 8'hAA;
        D1 = 8'hBB;
        tick();
        tick();
        checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", Q); end
        checks++; if (Gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", Gnt); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (Owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b want 0", Owner); end
        checks++; if (WrCount !== 8'd0) begin errors++; $display("FAIL reset_wrcount: got %0d want 0", WrCount); end
        Resetn = 1'b1;
        tick();
        exp_wr = 8'd1;
        checks++; if (Gnt !== 2'b01) begin errors++; $display("FAIL reset_first_gnt: got %b want 01", Gnt); end
        checks++; if (Q !== 8'hAA) begin errors++; $display("FAIL reset_first_q: got %h want aa", Q); end
        Req = 2'b00;
        tick();
        tick();
        tick();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_first_idle: busy got %b want 0", Busy); end
    endtask

    task automatic test_single_write();
        Req = 2'b01;
        D0 = 8'h3C;
        tick();
        exp_wr = exp_wr + 8'd1;
        Req = 2'b00;
        checks++; if (Gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", Gnt); end
        checks++; if (Q !== 8'h3C) begin errors++; $display("FAIL single_q: got %h want 3c", Q); end
        checks++; if (Owner !== 1'b0) begin errors++; $display("FAIL single_owner: got %b want 0", Owner); end
        checks++; if (WrCount !== exp_wr) begin errors++; $display("FAIL single_wrcount: got %0d want %0d", WrCount, exp_wr); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL single_busy0: got %b want 1", Busy); end
        tick();
        checks++; if (Gnt !== 2'b00) begin errors++; $display("FAIL single_gnt_width: got %b want 00", Gnt); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL single_busy1: got %b want 1", Busy); end
        tick();
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL single_busy2: got %b want 1", Busy); end
        tick();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL single_busy3: got %b want 0", Busy); end
    endtask

    task automatic test_hold_off();
        Req = 2'b01;
        D0 = 8'h77;
        tick();
        exp_wr = exp_wr + 8'd1;
        Req = 2'b00;
        tick();
        // Now in HOLD: a request from requester 1 must wait for Busy to fall.
        Req = 2'b10;
        D1 = 8'h5A;
        tick();
        checks++; if (Gnt !== 2'b00) begin errors++; $display("FAIL holdoff_gnt_hold: got %b want 00", Gnt); end
        tick();
        checks++; if (Gnt !== 2'b00) begin errors++; $display("FAIL holdoff_gnt_idle: got %b want 00", Gnt); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL holdoff_busy_idle: got %b want 0", Busy); end
        tick();
        exp_wr = exp_wr + 8'd1;
        Req = 2'b00;
        checks++; if (Gnt !== 2'b10) begin errors++; $display("FAIL holdoff_gnt: got %b want 10", Gnt); end
        checks++; if (Q !== 8'h5A) begin errors++; $display("FAIL holdoff_q: got %h want 5a", Q); end
        checks++; if (Owner !== 1'b1) begin errors++; $display("FAIL holdoff_owner: got %b want 1", Owner); end
        checks++; if (WrCount !== exp_wr) begin errors++; $display("FAIL holdoff_wrcount: got %0d want %0d", WrCount, exp_wr); end
        tick();
        tick();
        tick();
    endtask

    task automatic test_contention();
        logic [7:0] exp_q [4];
        logic [1:0] exp_g [4];
        exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h11; exp_q[3] = 8'h22;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        Req = 2'b11;
        D0 = 8'h11;
        D1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_wr = exp_wr + 8'd1;
            checks++; if (Gnt !== exp_g[k]) begin errors++; $display("FAIL contention_gnt[%0d]: got %b want %b", k, Gnt, exp_g[k]); end
            checks++; if (Q !== exp_q[k]) begin errors++; $display("FAIL contention_q[%0d]: got %h want %h", k, Q, exp_q[k]); end
            for (int j = 0; j < 3; j++) begin
                tick();
                checks++; if (Gnt !== 2'b00) begin errors++; $display("FAIL contention_gap[%0d.%0d]: got %b want 00", k, j, Gnt); end
            end
        end
        Req = 2'b00;
        checks++; if (WrCount !== exp_wr) begin errors++; $display("FAIL contention_wrcount: got %0d want %0d", WrCount, exp_wr); end
    endtask

    task automatic test_data_stability();
        Req = 2'b01;
        D0 = 8'h0F;
        tick();
        exp_wr = exp_wr + 8'd1;
        Req = 2'b00;
        D0 = 8'hFF;
        checks++; if (Q !== 8'h0F) begin errors++; $display("FAIL stable_q_grant: got %h want 0f", Q); end
        tick();
        checks++; if (Q !== 8'h0F) begin errors++; $display("FAIL stable_q_hold: got %h want 0f", Q); end
        tick();
        tick();
        tick();
        checks++; if (Q !== 8'h0F) begin errors++; $display("FAIL stable_q_idle: got %h want 0f", Q); end
        checks++; if (WrCount !== exp_wr) begin errors++; $display("FAIL stable_wrcount: got %0d want %0d", WrCount, exp_wr); end
    endtask

    task automatic test_wrap_and_reset();
        Req = 2'b00;
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
        tick();
        D0 = 8'h01;
        for (int n = 0; n < 255; n++) begin
            Req = 2'b01;
            tick();
            Req = 2'b00;
            tick();
            tick();
            tick();
        end
        checks++; if (WrCount !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", WrCount); end
        Req = 2'b01;
        tick();
        Req = 2'b00;
        checks++; if (WrCount !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d want 0", WrCount); end
        tick();
        tick();
        tick();
        // Reset in the middle of HOLD.
        Req = 2'b10;
        D1 = 8'hC3;
        tick();
        Req = 2'b00;
        tick();
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL midop_busy_before: got %b want 1", Busy); end
        checks++; if (Q !== 8'hC3) begin errors++; $display("FAIL midop_q_before: got %h want c3", Q); end
        Resetn = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midop_busy: got %b want 0", Busy); end
        checks++; if (Q !== 8'h00) begin errors++; $display("FAIL midop_q: got %h want 00", Q); end
        checks++; if (WrCount !== 8'd0) begin errors++; $display("FAIL midop_wrcount: got %0d want 0", WrCount); end
        checks++; if (Owner !== 1'b0) begin errors++; $display("FAIL midop_owner: got %b want 0", Owner); end
        tick();
        Resetn = 1'b1;
        Req = 2'b11;
        D0 = 8'hA5;
        D1 = 8'h5A;
        tick();
        Req = 2'b00;
        checks++; if (Gnt !== 2'b01) begin errors++; $display("FAIL midop_regrant_gnt: got %b want 01", Gnt); end
        checks++; if (Q !== 8'hA5) begin errors++; $display("FAIL midop_regrant_q: got %h want a5", Q); end
        checks++; if (WrCount !== 8'd1) begin errors++; $display("FAIL midop_regrant_wrcount: got %0d want 1", WrCount); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_wr = 8'd0;
        Resetn = 1'b0;
        Req = 2'b00;
        D0 = 8'h00;
        D1 = 8'h00;
        @(negedge Clk);
        test_reset();
        test_single_write();
        test_hold_off();
        test_contention();
        test_data_stability();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shared_dreg_arbiter.md
# shared_dreg_arbiter

Two-requester, round-robin arbiter that owns a single WIDTH-bit D-register bank and serialises writes into it. Each requester presents a level request plus data; the arbiter grants one requester at a time, captures its data into the shared register, and enforces a programmable hold-off window after every write. It sits between lab datapath sources (switch/key front ends) and the shared flip-flop bank whose output drives LEDs or downstream logic.

## Interface
- WIDTH, 8: data and register width (1..32).
- HOLD, 2: idle hold-off cycles after each grant cycle (0..15).

- Clk  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-low reset.
- Req  in  2  level requests; bit i belongs to requester i.
- D0  in  WIDTH  write data of requester 0.
- D1  in  WIDTH  write data of requester 1.
- Gnt  out  2  one-hot grant pulse, one cycle, registered.
- Q  out  WIDTH  shared register contents.
- Owner  out  1  index of the last requester written.
- Busy  out  1  high while in GRANT or HOLD.
- WrCount  out  8  total completed writes, modulo 256.

## Operation
- Reset (Resetn low, any time, asynchronous): state IDLE, Q=0, Gnt=00, Busy=0, Owner=0, WrCount=0, hold counter=0, priority pointer set so requester 0 wins the first tie. Reset mid-GRANT/HOLD aborts the sequence; no write counted beyond those already captured.
- States: IDLE, GRANT, HOLD.
- IDLE: at a clock edge with Req!=00, select winner w: only one bit set -> that requester; both set -> requester != last winner (round-robin). Same edge: Q<=Dw, Owner<=w, Gnt<=onehot(w), Busy<=1, WrCount<=WrCount+1 (255 wraps to 0), pointer<=w, state<=GRANT. Req=00: remain IDLE, outputs unchanged.
- GRANT: lasts exactly one cycle; Gnt high. Next edge: Gnt<=00; HOLD=0 -> IDLE, Busy<=0; else HOLD, counter<=HOLD-1.
- HOLD: Busy high, Gnt 00, Req ignored. Each edge: counter 0 -> IDLE, Busy<=0; else counter-1.
- Requester handshake: Req held high with stable data until Gnt[i] observed; requester deasserts on the following edge. Req still high when IDLE re-arbitrates counts as a new request.
- Data is sampled only on the grant edge; D changes at other times never affect Q.
- Fairness: with both Req continuously high, grants alternate 0,1,0,1...

## Timing
- Latency: Req high before edge E (IDLE) -> Q, Owner, Gnt, WrCount updated after E (one edge).
- Gnt width exactly 1 cycle; never both bits set.
- Busy high for HOLD+1 cycles per write.
- Minimum spacing between grant edges: HOLD+2 cycles (HOLD=2 -> 4 cycles).
- Req arriving during GRANT/HOLD is served at the first edge after Busy falls (earliest IDLE edge).
- All outputs registered; no combinational path from Req/D to outputs.

## Test plan
- Reset: Resetn=0 with Req=11, D0=8'hAA -> Q=00, Gnt=00, Busy=0, Owner=0, WrCount=0; release Resetn -> first grant to requester 0.
- Single write: Req=01, D0=8'h3C for one edge -> next cycle Gnt=01, Q=3C, Owner=0, WrCount=1; Busy high 3 cycles (HOLD=2), then low.
- Contention: Req=11 held, D0=8'h11, D1=8'h22 -> Q sequence 11,22,11,22 on grant edges 4 cycles apart; Gnt alternates 01,10.
- Hold-off: Req=10 asserted during HOLD with D1=8'h5A -> no Gnt until Busy=0; grant on first IDLE edge, Q=5A, Owner=1.
- Data stability: change D0 to 8'hFF one cycle after grant of 8'h0F -> Q stays 0F.
- Wrap and reset mid-op: 256 single writes -> WrCount wraps to 0; assert Resetn=0 mid-HOLD -> Busy=0, Q=00 immediately, next grant follows reset rules.
